// File: rtl/spi_slave_regs.sv
// SPI mode-0 target bridging to a byte-wide register-file port (cmd byte + data bytes).
// Define SPI_SLAVE_AUTOINC_EN to step reg_addr after every data byte; otherwise it stays fixed.
module spi_slave_regs #(
   parameter int AW          = 7,
   parameter int SYNC_STAGES = 2
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          SCLK,
   input  logic          SSn,
   input  logic          MOSI,
   output logic          MISO,
   output logic          MISO_oeb,
   output logic [AW-1:0] reg_addr,
   output logic [7:0]    reg_wdata,
   output logic          reg_we,
   output logic          reg_re,
   input  logic [7:0]    reg_rdata,
   output logic          frame_err
);

`ifdef SPI_SLAVE_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sclk_sy, ssn_sy, mosi_sy;
   logic                   sclk_d, ssn_d;
   logic [2:0]             bit_cnt;
   logic [7:0]             rx_shift, tx_shift;
   logic                   is_read, re_d, inc_pend;

   logic       sclk_s, ssn_s, mosi_s;
   logic       sclk_rise, sclk_fall, ssn_rise, ssn_fall, byte_done;
   logic [7:0] rx_next;
   logic [2:0] cnt_next;

   assign sclk_s    = sclk_sy[SYNC_STAGES-1];
   assign ssn_s     = ssn_sy[SYNC_STAGES-1];
   assign mosi_s    = mosi_sy[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign ssn_rise  = ssn_s & ~ssn_d;
   assign ssn_fall  = ~ssn_s & ssn_d;
   assign rx_next   = {rx_shift[6:0], mosi_s};
   assign cnt_next  = sclk_rise ? bit_cnt + 3'd1 : bit_cnt;
   assign byte_done = sclk_rise && (bit_cnt == 3'd7);

   // MISO is a decode of registers only; driven low outside a read data phase.
   assign MISO = (state == DATA) && is_read && tx_shift[7];

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         // SSn chain resets low so a frame already in progress cannot produce a fall edge.
         sclk_sy   <= '0;
         ssn_sy    <= '0;
         mosi_sy   <= '0;
         sclk_d    <= 1'b0;
         ssn_d     <= 1'b0;
         state     <= IDLE;
         bit_cnt   <= 3'd0;
         rx_shift  <= 8'h00;
         tx_shift  <= 8'h00;
         is_read   <= 1'b0;
         re_d      <= 1'b0;
         inc_pend  <= 1'b0;
         MISO_oeb  <= 1'b1;
         reg_addr  <= '0;
         reg_wdata <= 8'h00;
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         sclk_sy   <= {sclk_sy[SYNC_STAGES-2:0], SCLK};
         ssn_sy    <= {ssn_sy[SYNC_STAGES-2:0], SSn};
         mosi_sy   <= {mosi_sy[SYNC_STAGES-2:0], MOSI};
         sclk_d    <= sclk_s;
         ssn_d     <= ssn_s;
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
         frame_err <= 1'b0;
         re_d      <= reg_re;
         inc_pend  <= 1'b0;
         if (inc_pend)
            reg_addr <= reg_addr + 1'b1;

         case (state)
            IDLE: begin
               if (ssn_fall) begin
                  state    <= CMD;
                  bit_cnt  <= 3'd0;
                  rx_shift <= 8'h00;
                  MISO_oeb <= 1'b0;
               end
            end
            CMD, DATA: begin
               if (sclk_rise) begin
                  rx_shift <= rx_next;
                  bit_cnt  <= cnt_next;
               end
               // No shift on the fall right after a byte boundary: the reload already put bit 7 out.
               if (sclk_fall && state == DATA && is_read && bit_cnt != 3'd0)
                  tx_shift <= {tx_shift[6:0], 1'b0};
               if (byte_done) begin
                  if (state == CMD) begin
                     reg_addr <= rx_next[AW-1:0];
                     is_read  <= rx_next[7];
                     reg_re   <= rx_next[7];
                     state    <= DATA;
                  end else if (is_read) begin
                     if (AUTOINC)
                        reg_addr <= reg_addr + 1'b1;
                     reg_re <= 1'b1;
                  end else begin
                     reg_we    <= 1'b1;
                     reg_wdata <= rx_next;
                     inc_pend  <= AUTOINC;
                  end
               end
               if (ssn_rise) begin
                  state     <= IDLE;
                  MISO_oeb  <= 1'b1;
                  bit_cnt   <= 3'd0;
                  frame_err <= (cnt_next != 3'd0);
               end
            end
            default: state <= IDLE;
         endcase

         // Read data arrives one cycle after the strobe; loading wins over a same-cycle shift.
         if (re_d)
            tx_shift <= reg_rdata;
      end
   end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Scoreboard bench for spi_slave_regs: SPI master tasks, register-file model, strobe monitor.
module tb_spi_slave_regs;

`ifdef SPI_SLAVE_AUTOINC_EN
   localparam bit AI = 1'b1;
`else
   localparam bit AI = 1'b0;
`endif
   localparam int HALF = 100;

   logic       wb_clk_i = 1'b0;
   logic       wb_rst_i, SCLK, SSn, MOSI;
   logic       MISO, MISO_oeb;
   logic [6:0] reg_addr;
   logic [7:0] reg_wdata, reg_rdata;
   logic       reg_we, reg_re, frame_err;

   int n_chk = 0;
   int n_err = 0;
   int fe_seen = 0;
   logic fe_prev = 1'b0;
   logic [15:0] we_q[$];
   logic [6:0]  re_q[$];
   logic [7:0]  mem[128];

   spi_slave_regs #(.AW(7), .SYNC_STAGES(2)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .SCLK(SCLK), .SSn(SSn), .MOSI(MOSI),
      .MISO(MISO), .MISO_oeb(MISO_oeb), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .frame_err(frame_err)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Registered read port: data valid the cycle after reg_re.
   initial reg_rdata = 8'h00;
   always @(posedge wb_clk_i)
      if (reg_re) reg_rdata <= mem[reg_addr];

   always @(negedge wb_clk_i) begin
      if (!wb_rst_i) begin
         if (reg_we || reg_re) chk("we_re_excl", {31'd0, reg_we & reg_re}, 32'd0);
         if (reg_we) begin
            chk("we_expected", {31'd0, we_q.size() != 0}, 32'd1);
            if (we_q.size() != 0) begin
               logic [15:0] e;
               e = we_q.pop_front();
               chk("we_addr", {25'd0, reg_addr}, {24'd0, e[15:8]});
               chk("we_data", {24'd0, reg_wdata}, {24'd0, e[7:0]});
            end
         end
         if (reg_re) begin
            chk("re_expected", {31'd0, re_q.size() != 0}, 32'd1);
            if (re_q.size() != 0) chk("re_addr", {25'd0, reg_addr}, {25'd0, re_q.pop_front()});
         end
         if (frame_err) begin
            chk("fe_width", {31'd0, fe_prev}, 32'd0);
            fe_seen <= fe_seen + 1;
         end
      end
      fe_prev <= frame_err;
   end

   task automatic ss_low();
      SSn = 1'b0;
      #HALF;
      chk("oeb_selected", {31'd0, MISO_oeb}, 32'd0);
   endtask

   task automatic ss_high();
      #HALF;
      SSn = 1'b1;
      #(3*HALF);
      chk("oeb_deselected", {31'd0, MISO_oeb}, 32'd1);
   endtask

   task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         MOSI = tx[i];
         #HALF;
         SCLK = 1'b1;
         rx[i] = MISO;
         #HALF;
         SCLK = 1'b0;
      end
   endtask

   function automatic logic [6:0] nxt(input logic [6:0] a);
      return AI ? a + 7'd1 : a;
   endfunction

   initial begin
      logic [7:0] rx;
      for (int i = 0; i < 128; i++) mem[i] = 8'(i ^ 8'h55);
      mem[5] = 8'h3C; mem[6] = 8'hC3; mem[7] = 8'h5A;
      SSn = 1'b1; SCLK = 1'b0; MOSI = 1'b0; wb_rst_i = 1'b1;
      repeat (4) @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      chk("rst_miso", {31'd0, MISO}, 32'd0);
      chk("rst_oeb", {31'd0, MISO_oeb}, 32'd1);
      chk("rst_addr", {25'd0, reg_addr}, 32'd0);
      chk("rst_wdata", {24'd0, reg_wdata}, 32'd0);
      chk("rst_we_re_fe", {29'd0, reg_we, reg_re, frame_err}, 32'd0);
      wb_rst_i = 1'b0;
      #HALF;

      // single write
      we_q.push_back({8'h05, 8'hA5});
      ss_low(); xfer(8'h05, 8, rx); xfer(8'hA5, 8, rx); ss_high();
      chk("t1_fe_none", fe_seen, 32'd0);

      // single read: strobe for the data byte, then prefetch for the next
      re_q.push_back(7'h05); re_q.push_back(nxt(7'h05));
      ss_low();
      xfer(8'h85, 8, rx); chk("t2_miso_cmd", {24'd0, rx}, 32'd0);
      xfer(8'h00, 8, rx); chk("t2_miso_data", {24'd0, rx}, 32'h3C);
      ss_high();

      // two-byte write across the address wrap
      we_q.push_back({8'h7F, 8'h11}); we_q.push_back({1'b0, nxt(7'h7F), 8'h22});
      ss_low(); xfer(8'h7F, 8, rx); xfer(8'h11, 8, rx); xfer(8'h22, 8, rx); ss_high();

      // two-byte read
      re_q.push_back(7'h06); re_q.push_back(nxt(7'h06)); re_q.push_back(nxt(nxt(7'h06)));
      ss_low();
      xfer(8'h86, 8, rx);
      xfer(8'h00, 8, rx); chk("rd2_byte0", {24'd0, rx}, 32'hC3);
      xfer(8'h00, 8, rx); chk("rd2_byte1", {24'd0, rx}, AI ? 32'h5A : 32'hC3);
      ss_high();
      chk("fe_none_yet", fe_seen, 32'd0);

      // abort after 4 data bits: first byte lands, partial one does not
      we_q.push_back({8'h10, 8'h33});
      ss_low(); xfer(8'h10, 8, rx); xfer(8'h33, 8, rx); xfer(8'hF0, 4, rx); ss_high();
      chk("t4_fe_pulse", fe_seen, 32'd1);

      // SCLK activity while deselected
      for (int i = 0; i < 16; i++) begin
         MOSI = 1'($urandom);
         SCLK = ~SCLK;
         #HALF;
      end
      SCLK = 1'b0;
      #HALF;
      chk("t6_oeb_idle", {31'd0, MISO_oeb}, 32'd1);

      // reset in the middle of a read, SSn kept low
      re_q.push_back(7'h05);
      ss_low(); xfer(8'h85, 8, rx); xfer(8'h00, 3, rx);
      wb_rst_i = 1'b1;
      #50;
      chk("t5_rst_miso_oeb", {30'd0, MISO, MISO_oeb}, 32'd1);
      chk("t5_rst_addr", {25'd0, reg_addr}, 32'd0);
      chk("t5_rst_strobes", {29'd0, reg_we, reg_re, frame_err}, 32'd0);
      wb_rst_i = 1'b0;
      #HALF;
      xfer(8'hFF, 8, rx);
      chk("t5_oeb_ignored", {31'd0, MISO_oeb}, 32'd1);
      ss_high();
      we_q.push_back({8'h01, 8'h99});
      ss_low(); xfer(8'h01, 8, rx); xfer(8'h99, 8, rx); ss_high();

      #(4*HALF);
      chk("fe_total", fe_seen, 32'd1);
      chk("we_q_drained", we_q.size(), 32'd0);
      chk("re_q_drained", re_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
